// File: rtl/stage_four.sv
// stage_four: four-slot elastic valid/ack pipeline carrying a DATA_W-bit token, one slot per clock
//   clk, rst                    : clock, synchronous active-high reset
//   valid_in, data_in, ack_out  : upstream port (ack_out = slot 0 can take data_in this cycle)
//   valid_out, data_out, ack_in : downstream port (oldest token, registered in the last slot)
module stage_four #(
    parameter int DATA_W = 3,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              ack_out,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
    input  logic              ack_in
);
    logic [DEPTH-1:0]  v, mv, ld;
    logic [DATA_W-1:0] d   [DEPTH];
    logic [DATA_W-1:0] src [DEPTH];
    // mv[i]: token in slot i moves on this edge; ripples ack_in upstream so a full pipe never bubbles
    always_comb begin
        mv = '0;
        mv[DEPTH-1] = v[DEPTH-1] & ack_in;
        for (int i = DEPTH - 2; i >= 0; i--) mv[i] = v[i] & (~v[i+1] | mv[i+1]);
    end
    assign ack_out = ~rst & (~v[0] | mv[0]);
    always_comb begin
        ld = '0;
        ld[0] = valid_in & ack_out;
        src[0] = data_in;
        for (int i = 1; i < DEPTH; i++) begin
            ld[i] = mv[i-1];
            src[i] = d[i-1];
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
            for (int i = 0; i < DEPTH; i++) d[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ld[i]) begin
                    d[i] <= src[i];
                    v[i] <= 1'b1;
                end else if (mv[i]) begin
                    v[i] <= 1'b0;
                end
            end
        end
    end
    assign valid_out = v[DEPTH-1];
    assign data_out  = d[DEPTH-1];
endmodule

// File: tb/tb_stage_four.sv
// tb_stage_four: directed table-driven bench for stage_four plus full-drain and mid-flight reset sequences
module tb_stage_four;
    logic       clk = 1'b0;
    logic       rst, valid_in, ack_in, ack_out, valid_out;
    logic [2:0] data_in, data_out;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    stage_four dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in), .ack_out(ack_out),
        .valid_out(valid_out), .data_out(data_out), .ack_in(ack_in)
    );

    typedef struct {
        int r, vi, di, ai, ea, ev, ed;
    } vec_t;
    vec_t tbl[31];

    // drive inputs on the falling edge, then let combinational outputs settle
    task automatic step(input int r, input int vi, input int di, input int ai);
        @(negedge clk);
        rst = r[0];
        valid_in = vi[0];
        data_in = di[2:0];
        ack_in = ai[0];
        #1;
    endtask

    task automatic chk(input string name, input int ea, input int ev, input int ed);
        checks++;
        if (ack_out !== ea[0] || valid_out !== ev[0] || data_out !== ed[2:0]) begin
            errors++;
            $display("FAIL %s: got ack_out=%b valid_out=%b data_out=%0d, expected ack_out=%0d valid_out=%0d data_out=%0d",
                     name, ack_out, valid_out, data_out, ea, ev, ed);
        end
    endtask

    task automatic sc(input string name, input int r, input int vi, input int di, input int ai,
                      input int ea, input int ev, input int ed);
        step(r, vi, di, ai);
        chk(name, ea, ev, ed);
    endtask

    initial begin
        rst = 1'b1;
        valid_in = 1'b0;
        data_in = 3'd0;
        ack_in = 1'b0;
        //        r vi di ai  ea ev ed
        tbl = '{
            '{1, 0, 0, 0,  0, 0, 0},
            '{0, 0, 0, 0,  1, 0, 0},
            '{0, 1, 1, 1,  1, 0, 0},
            '{0, 0, 7, 1,  1, 0, 0},
            '{0, 0, 7, 1,  1, 0, 0},
            '{0, 0, 7, 1,  1, 0, 0},
            '{0, 0, 7, 1,  1, 1, 1},
            '{0, 0, 7, 1,  1, 0, 1},
            '{0, 1, 1, 0,  1, 0, 1},
            '{0, 1, 2, 0,  1, 0, 1},
            '{0, 1, 3, 0,  1, 0, 1},
            '{0, 1, 4, 0,  1, 0, 1},
            '{0, 1, 5, 0,  0, 1, 1},
            '{0, 1, 5, 0,  0, 1, 1},
            '{0, 1, 5, 1,  1, 1, 1},
            '{0, 0, 7, 1,  1, 1, 2},
            '{0, 0, 7, 1,  1, 1, 3},
            '{0, 0, 7, 1,  1, 1, 4},
            '{0, 0, 7, 1,  1, 1, 5},
            '{0, 0, 7, 1,  1, 0, 5},
            '{0, 1, 1, 1,  1, 0, 5},
            '{0, 1, 2, 1,  1, 0, 5},
            '{0, 1, 3, 1,  1, 0, 5},
            '{0, 1, 4, 1,  1, 0, 5},
            '{0, 1, 5, 1,  1, 1, 1},
            '{0, 1, 6, 1,  1, 1, 2},
            '{0, 0, 7, 1,  1, 1, 3},
            '{0, 0, 7, 1,  1, 1, 4},
            '{0, 0, 7, 1,  1, 1, 5},
            '{0, 0, 7, 1,  1, 1, 6},
            '{0, 0, 7, 1,  1, 0, 6}
        };
        @(posedge clk);
        for (int i = 0; i < 31; i++)
            sc($sformatf("vec%0d", i), tbl[i].r, tbl[i].vi, tbl[i].di, tbl[i].ai,
               tbl[i].ea, tbl[i].ev, tbl[i].ed);

        // fill with 1..4, then drain one and accept one in the same cycle
        sc("fill1", 0, 1, 1, 0, 1, 0, 6);
        sc("fill2", 0, 1, 2, 0, 1, 0, 6);
        sc("fill3", 0, 1, 3, 0, 1, 0, 6);
        sc("fill4", 0, 1, 4, 0, 1, 0, 6);
        sc("full_stall", 0, 1, 5, 0, 0, 1, 1);
        sc("full_swap", 0, 1, 5, 1, 1, 1, 1);
        sc("still_full", 0, 0, 7, 0, 0, 1, 2);
        sc("drain2", 0, 0, 7, 1, 1, 1, 2);
        sc("drain3", 0, 0, 7, 1, 1, 1, 3);
        sc("drain4", 0, 0, 7, 1, 1, 1, 4);
        sc("drain5", 0, 0, 7, 1, 1, 1, 5);
        sc("drained", 0, 0, 7, 1, 1, 0, 5);

        // three tokens in flight, then a single reset edge discards them
        sc("load1", 0, 1, 1, 0, 1, 0, 5);
        sc("load2", 0, 1, 2, 0, 1, 0, 5);
        sc("load3", 0, 1, 3, 0, 1, 0, 5);
        sc("mid_rst", 1, 1, 4, 1, 0, 0, 5);
        sc("post_rst", 0, 0, 7, 1, 1, 0, 0);
        sc("after_in", 0, 1, 6, 1, 1, 0, 0);
        sc("after_a", 0, 0, 7, 1, 1, 0, 0);
        sc("after_b", 0, 0, 7, 1, 1, 0, 0);
        sc("after_c", 0, 0, 7, 1, 1, 0, 0);
        sc("after_out", 0, 0, 7, 1, 1, 1, 6);
        sc("after_gone", 0, 0, 7, 1, 1, 0, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
